fractal_sync_arb: RTL and testbench
===================================

FRACTAL_SYNC_ARB -- requirements
Module: fractal_sync_arb

Interface
REQ-001 Parameter: N_REQ, default 4, number of local requesters sharing one fractal sync port (legal 2..16).
REQ-002 Parameter: LVL_W, default 8, synchronization level width.
REQ-003 Parameter: ID_W, default 8, barrier id width.
REQ-004 Parameter: MAX_ERR, default 3, max allowed |response level - requested level| before error.
REQ-005 Parameter: TIMEOUT_CYC, default 1024, watchdog limit (used only when FSYNC_ARB_TIMEOUT_EN is defined).
REQ-006 Port: clk_i  in  1  single clock; all logic on rising edge.
REQ-007 Port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 Port: req_valid_i / req_ready_o  in / out  N_REQ  per-requester valid/ready handshake.
REQ-009 Port: req_level_i / req_id_i  in  N_REQ*LVL_W / N_REQ*ID_W  per-requester level and barrier id.
REQ-010 Port: rsp_valid_o / rsp_error_o  out  N_REQ  one-cycle response pulse and error flag per requester.
REQ-011 Port: rsp_level_o  out  N_REQ*LVL_W  level reported with the response.
REQ-012 Port: sync_valid_o / sync_ready_i  out / in  1  upstream request handshake.
REQ-013 Port: sync_level_o / sync_id_o / sync_src_o  out  LVL_W / ID_W / clog2(N_REQ)  upstream payload and source tag.
REQ-014 Port: sync_rsp_valid_i / sync_rsp_error_i  in  1  upstream response pulse and error (no backpressure).
REQ-015 Port: sync_rsp_src_i / sync_rsp_level_i  in  clog2(N_REQ) / LVL_W  response source tag and reached level.
REQ-016 Port: busy_o  out  N_REQ  pending bitmap (request accepted, response not yet delivered).

Function
REQ-017 Eligible set = req_valid_i & ~pending & ~stale; round-robin grant starting at rr_ptr; rr_ptr <- granted index+1 (mod N_REQ) on each accept.
REQ-018 req_ready_o[i] = grant[i] & (~sync_valid_o | sync_ready_i); at most one accept per cycle.
REQ-019 Accepted request registered into output stage: sync_valid_o high the cycle after accept (latency 1); payload held stable while sync_valid_o & ~sync_ready_i.
REQ-020 On accept: pending[i] <- 1, requested level stored per requester.
REQ-021 Response with pending[src]: next cycle rsp_valid_o[src]=1 for exactly one cycle, rsp_level_o[src]=sync_rsp_level_i, pending[src] <- 0.
REQ-022 rsp_error_o[src] = sync_rsp_error_i OR |sync_rsp_level_i - stored level| > MAX_ERR (unsigned, LVL_W+1-bit difference).
REQ-023 Response with src not pending, or src >= N_REQ: dropped, no output pulse.
REQ-024 Response and new request for same requester in same cycle: request not eligible that cycle (pending still set); eligible from next cycle.
REQ-025 Multiple requesters may be pending simultaneously; responses may return in any order.
REQ-026 rsp_level_o/rsp_error_o are zero whenever the corresponding rsp_valid_o is low.

Reset
REQ-027 On rst_ni low, immediately: sync_valid_o, rsp_valid_o, rsp_error_o, busy_o, req_ready_o = 0; all payload outputs 0; pending, stale, rr_ptr, counters = 0.
REQ-028 Reset mid-transaction discards all in-flight state; no response generated after reset release.

Configuration
REQ-029 Macro FSYNC_ARB_TIMEOUT_EN defined: per-requester counter runs while pending and the request has left the output stage; at TIMEOUT_CYC cycles, rsp_valid_o pulse with rsp_error_o=1, rsp_level_o=stored level, pending cleared, stale[i] set.
REQ-030 With macro: while stale[i], requester i not eligible; next upstream response for src i is dropped and clears stale[i].
REQ-031 Macro undefined: no counters/stale logic; requester waits indefinitely for a response.

Verification
REQ-032 Reqs 0..3 valid together, sync_ready_i=1 -> upstream src order 0,1,2,3 on consecutive cycles, busy_o=4'hF.
REQ-033 Req 2 level 5, response src 2 level 7 err 0 -> rsp_valid_o[2] pulse, level 7, rsp_error_o[2]=0; level 9 -> rsp_error_o[2]=1.
REQ-034 sync_ready_i low 10 cycles with req 1 pending -> sync payload stable, no further req_ready_o.
REQ-035 Response src 3 while only req 0 pending -> no rsp_valid_o, busy_o unchanged.
REQ-036 FSYNC_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no response -> rsp_error_o[0]=1 at cycle 16, late response dropped, new req 0 accepted after it.

Source files
------------

// File: rtl/fractal_sync_arb_if.sv
// Signal bundle between the local requesters, the fractal sync arbiter and the
// upstream fractal sync port. The arbiter uses the master modport.
interface fractal_sync_arb_if #(
  parameter int N_REQ = 4,
  parameter int LVL_W = 8,
  parameter int ID_W  = 8
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*LVL_W-1:0] req_level_i;
  logic [N_REQ*ID_W-1:0]  req_id_i;
  logic [N_REQ-1:0]       rsp_valid_o;
  logic [N_REQ-1:0]       rsp_error_o;
  logic [N_REQ*LVL_W-1:0] rsp_level_o;
  logic                   sync_valid_o;
  logic                   sync_ready_i;
  logic [LVL_W-1:0]       sync_level_o;
  logic [ID_W-1:0]        sync_id_o;
  logic [SRC_W-1:0]       sync_src_o;
  logic                   sync_rsp_valid_i;
  logic                   sync_rsp_error_i;
  logic [SRC_W-1:0]       sync_rsp_src_i;
  logic [LVL_W-1:0]       sync_rsp_level_i;
  logic [N_REQ-1:0]       busy_o;

  modport master (
    input  req_valid_i, req_level_i, req_id_i, sync_ready_i,
           sync_rsp_valid_i, sync_rsp_error_i, sync_rsp_src_i, sync_rsp_level_i,
    output req_ready_o, rsp_valid_o, rsp_error_o, rsp_level_o,
           sync_valid_o, sync_level_o, sync_id_o, sync_src_o, busy_o
  );

  modport slave (
    output req_valid_i, req_level_i, req_id_i, sync_ready_i,
           sync_rsp_valid_i, sync_rsp_error_i, sync_rsp_src_i, sync_rsp_level_i,
    input  req_ready_o, rsp_valid_o, rsp_error_o, rsp_level_o,
           sync_valid_o, sync_level_o, sync_id_o, sync_src_o, busy_o
  );
endinterface

// File: rtl/fractal_sync_arb.sv
// Round-robin arbiter sharing one fractal sync port among N_REQ requesters.
// Optional per-requester watchdog enabled by defining FSYNC_ARB_TIMEOUT_EN.
module fractal_sync_arb #(
  parameter int N_REQ       = 4,
  parameter int LVL_W       = 8,
  parameter int ID_W        = 8,
  parameter int MAX_ERR     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fractal_sync_arb_if.master bus
);
  localparam int SRC_W = $clog2(N_REQ);
  localparam int SRC_N = 1 << SRC_W;

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("fractal_sync_arb: illegal parameter set");
  end

  logic [N_REQ-1:0]            pending_q, stale, tmo, eligible, grant, req_ready, rsp_hit;
  logic [N_REQ-1:0]            rsp_valid_q, rsp_error_q;
  logic [N_REQ-1:0][LVL_W-1:0] rsp_level_q, lvl_q;
  logic [SRC_W-1:0]            rr_ptr_q, grant_idx, sync_src_q;
  logic [LVL_W-1:0]            grant_level, sync_level_q, rsp_ref_level;
  logic [ID_W-1:0]             grant_id, sync_id_q;
  logic                        sync_valid_q, out_free, accept, rsp_known, lvl_err;
  logic [SRC_N-1:0]            pending_ext;
  logic [LVL_W:0]              lvl_diff;

  assign eligible = bus.req_valid_i & ~pending_q & ~stale;
  assign out_free = ~sync_valid_q | bus.sync_ready_i;

  // NOTE: every signal driven by always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : arbiter
    int  idx;
    logic found;
    grant       = '0;
    grant_idx   = '0;
    grant_level = '0;
    grant_id    = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = SRC_W'(idx);
        grant_level = bus.req_level_i[idx*LVL_W +: LVL_W];
        grant_id    = bus.req_id_i[idx*ID_W +: ID_W];
      end
    end
  end

  // Reset is also applied combinationally so ready is low for the whole reset window.
  assign req_ready = grant & {N_REQ{out_free & rst_ni}};
  assign accept    = |req_ready;

  always_comb begin : rsp_decode
    pending_ext              = '0;
    pending_ext[N_REQ-1:0]   = pending_q;
    rsp_known                = bus.sync_rsp_valid_i & pending_ext[bus.sync_rsp_src_i];
    rsp_ref_level            = '0;
    rsp_hit                  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.sync_rsp_src_i == SRC_W'(i)) rsp_ref_level = lvl_q[i];
      rsp_hit[i] = rsp_known & (bus.sync_rsp_src_i == SRC_W'(i));
    end
    lvl_diff = {1'b0, bus.sync_rsp_level_i} - {1'b0, rsp_ref_level};
    if (lvl_diff[LVL_W]) lvl_diff = -lvl_diff;
    lvl_err = lvl_diff > (LVL_W+1)'(MAX_ERR);
  end

`ifdef FSYNC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [N_REQ-1:0][CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0]            stale_q, in_stage;

  // The watchdog only runs once the request has actually left the output stage.
  always_comb begin : watchdog
    in_stage = '0;
    tmo      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      in_stage[i] = sync_valid_q & (sync_src_q == SRC_W'(i));
      tmo[i]      = pending_q[i] & ~in_stage[i] & ~rsp_hit[i] &
                    (cnt_q[i] == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

  assign stale = stale_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pending_q[i] || in_stage[i] || tmo[i]) cnt_q[i] <= '0;
        else                                        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        if (tmo[i]) stale_q[i] <= 1'b1;
        else if (bus.sync_rsp_valid_i && bus.sync_rsp_src_i == SRC_W'(i)) stale_q[i] <= 1'b0;
      end
    end
  end
`else
  assign stale = '0;
  assign tmo   = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      pending_q    <= '0;
      sync_valid_q <= 1'b0;
      sync_level_q <= '0;
      sync_id_q    <= '0;
      sync_src_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_error_q  <= '0;
      rsp_level_q  <= '0;
      // NOTE: lvl_q is a handful of flops, not a RAM, so it is reset with the rest to keep it X-free.
      lvl_q        <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q     <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        sync_valid_q <= 1'b1;
        sync_level_q <= grant_level;
        sync_id_q    <= grant_id;
        sync_src_q   <= grant_idx;
      end else if (bus.sync_ready_i) begin
        sync_valid_q <= 1'b0;
      end
      pending_q <= (pending_q | req_ready) & ~(rsp_hit | tmo);
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid_q[i] <= rsp_hit[i] | tmo[i];
        rsp_error_q[i] <= (rsp_hit[i] & (bus.sync_rsp_error_i | lvl_err)) | tmo[i];
        rsp_level_q[i] <= rsp_hit[i] ? bus.sync_rsp_level_i :
                          (tmo[i] ? lvl_q[i] : '0);
        if (req_ready[i]) lvl_q[i] <= grant_level;
      end
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.sync_valid_o = sync_valid_q;
  assign bus.sync_level_o = sync_level_q;
  assign bus.sync_id_o    = sync_id_q;
  assign bus.sync_src_o   = sync_src_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_error_o  = rsp_error_q;
  assign bus.rsp_level_o  = rsp_level_q;
  assign bus.busy_o       = pending_q;
endmodule

// File: tb/tb_fractal_sync_arb.sv
// Scoreboard bench for fractal_sync_arb: upstream requests and local responses
// are predicted when stimulus is driven and compared when the DUT emits them.
module tb_fractal_sync_arb;
  localparam int N       = 4;
  localparam int LW      = 8;
  localparam int IW      = 8;
  localparam int MAX_ERR = 3;
  localparam int TMO     = 16;
  localparam int SW      = 2;

  typedef struct {
    logic [SW-1:0] src;
    logic [LW-1:0] lvl;
    logic [IW-1:0] id;
  } up_t;

  typedef struct {
    logic [SW-1:0] src;
    logic [LW-1:0] lvl;
    logic          err;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fractal_sync_arb_if #(.N_REQ(N), .LVL_W(LW), .ID_W(IW)) bus ();

  fractal_sync_arb #(
    .N_REQ(N), .LVL_W(LW), .ID_W(IW), .MAX_ERR(MAX_ERR), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int            n_tests  = 0;
  int            n_fail   = 0;
  int            hs_count = 0;
  up_t           exp_up[$];
  rsp_t          exp_rsp[$];
  logic [LW-1:0] exp_lvl[N];
  up_t           mon_up;
  rsp_t          mon_rsp;
  logic [N*LW-1:0] mon_lvl_vec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rsp_err(input logic [LW-1:0] req_lvl, input logic [LW-1:0] rsp_lvl,
                                   input logic err);
    int d;
    d = int'(rsp_lvl) - int'(req_lvl);
    if (d < 0) d = -d;
    return err || (d > MAX_ERR);
  endfunction

  // Output monitor: compares every upstream handshake and every response pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sync_valid_o && bus.sync_ready_i) begin
        hs_count++;
        if (exp_up.size() == 0) check("up_unexpected", exp_up.size(), 1);
        else begin
          mon_up = exp_up.pop_front();
          check("up_src", bus.sync_src_o, mon_up.src);
          check("up_lvl", bus.sync_level_o, mon_up.lvl);
          check("up_id", bus.sync_id_o, mon_up.id);
        end
      end
      if (bus.rsp_valid_o != '0) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", bus.rsp_valid_o, 0);
        else begin
          mon_rsp     = exp_rsp.pop_front();
          mon_lvl_vec = '0;
          mon_lvl_vec[mon_rsp.src*LW +: LW] = mon_rsp.lvl;
          check("rsp_valid", bus.rsp_valid_o, N'(1) << mon_rsp.src);
          check("rsp_level", bus.rsp_level_o, mon_lvl_vec);
          check("rsp_error", bus.rsp_error_o, N'(mon_rsp.err) << mon_rsp.src);
        end
      end else begin
        check("rsp_idle_zero", {bus.rsp_error_o, bus.rsp_level_o}, 0);
      end
    end
  end

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid_i & bus.req_ready_o;
    @(posedge clk);
    #1 bus.req_valid_i = bus.req_valid_i & ~acc;
  endtask

  task automatic set_req(input int i, input logic [LW-1:0] lvl, input logic [IW-1:0] id);
    bus.req_level_i[i*LW +: LW] = lvl;
    bus.req_id_i[i*IW +: IW]    = id;
    bus.req_valid_i[i]          = 1'b1;
    exp_up.push_back('{src: SW'(i), lvl: lvl, id: id});
    exp_lvl[i] = lvl;
  endtask

  task automatic wait_acc(input logic [N-1:0] mask, input string tag);
    for (int c = 0; c < 20 && (bus.req_valid_i & mask) != '0; c++) step();
    check(tag, bus.req_valid_i & mask, 0);
  endtask

  task automatic send_rsp(input int src, input logic [LW-1:0] lvl, input logic err,
                          input logic expect_out);
    bus.sync_rsp_valid_i = 1'b1;
    bus.sync_rsp_src_i   = SW'(src);
    bus.sync_rsp_level_i = lvl;
    bus.sync_rsp_error_i = err;
    if (expect_out) exp_rsp.push_back('{src: SW'(src), lvl: lvl, err: rsp_err(exp_lvl[src], lvl, err)});
    step();
    bus.sync_rsp_valid_i = 1'b0;
    bus.sync_rsp_error_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    bus.req_valid_i      = '0;
    bus.req_level_i      = '0;
    bus.req_id_i         = '0;
    bus.sync_ready_i     = 1'b1;
    bus.sync_rsp_valid_i = 1'b0;
    bus.sync_rsp_error_i = 1'b0;
    bus.sync_rsp_src_i   = '0;
    bus.sync_rsp_level_i = '0;
    for (int i = 0; i < N; i++) exp_lvl[i] = '0;

    // Reset state, with every requester asserting valid.
    bus.req_valid_i = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_sync_valid", bus.sync_valid_o, 0);
    check("rst_sync_payload", {bus.sync_level_o, bus.sync_id_o, bus.sync_src_o}, 0);
    check("rst_rsp", {bus.rsp_valid_o, bus.rsp_error_o, bus.rsp_level_o}, 0);
    bus.req_valid_i = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All four requesters together: round-robin order 0..3 on consecutive cycles.
    for (int i = 0; i < N; i++) set_req(i, LW'(10 + i), IW'('h20 + i));
    hs0 = hs_count;
    repeat (5) step();
    check("burst_handshakes", hs_count - hs0, 4);
    check("burst_busy", bus.busy_o, 4'hF);
    check("burst_all_accepted", bus.req_valid_i, 0);
    send_rsp(3, 8'd16, 1'b0, 1'b1);
    send_rsp(0, 8'd10, 1'b1, 1'b1);
    send_rsp(2, 8'd6,  1'b0, 1'b1);
    send_rsp(1, 8'd20, 1'b0, 1'b1);
    step();
    check("burst_busy_cleared", bus.busy_o, 0);

    // Level tolerance on requester 2: +2 is fine, +4 is an error.
    set_req(2, 8'd5, 8'h52);
    wait_acc(4'b0100, "acc_req2_a");
    step();
    send_rsp(2, 8'd7, 1'b0, 1'b1);
    step();
    set_req(2, 8'd5, 8'h53);
    wait_acc(4'b0100, "acc_req2_b");
    step();
    send_rsp(2, 8'd9, 1'b0, 1'b1);
    step();

    // Upstream stall: payload must hold and nothing else gets accepted.
    bus.sync_ready_i = 1'b0;
    set_req(1, 8'd33, 8'h61);
    wait_acc(4'b0010, "acc_req1_stall");
    set_req(0, 8'd44, 8'h70);
    for (int c = 0; c < 10; c++) begin
      step();
      check("stall_valid", bus.sync_valid_o, 1);
      check("stall_payload", {bus.sync_src_o, bus.sync_level_o, bus.sync_id_o}, {2'd1, 8'd33, 8'h61});
      check("stall_no_ready", bus.req_ready_o, 0);
    end
    bus.sync_ready_i = 1'b1;
    wait_acc(4'b0001, "acc_req0_after_stall");
    step();
    step();
    send_rsp(1, 8'd33, 1'b0, 1'b1);
    send_rsp(0, 8'd47, 1'b0, 1'b1);
    step();

    // Response for a requester that is not pending is dropped.
    set_req(0, 8'd50, 8'h80);
    wait_acc(4'b0001, "acc_req0_drop");
    step();
    send_rsp(3, 8'd50, 1'b0, 1'b0);
    step();
    step();
    check("drop_busy", bus.busy_o, 4'b0001);
    send_rsp(0, 8'd50, 1'b0, 1'b1);
    step();

    // Response and new request for the same requester in one cycle.
    set_req(0, 8'd60, 8'h90);
    wait_acc(4'b0001, "acc_req0_same");
    step();
    bus.sync_rsp_valid_i = 1'b1;
    bus.sync_rsp_src_i   = 2'd0;
    bus.sync_rsp_level_i = 8'd61;
    bus.sync_rsp_error_i = 1'b0;
    exp_rsp.push_back('{src: 2'd0, lvl: 8'd61, err: rsp_err(exp_lvl[0], 8'd61, 1'b0)});
    set_req(0, 8'd70, 8'h91);
    #1;
    check("same_cycle_not_ready", bus.req_ready_o[0], 0);
    step();
    bus.sync_rsp_valid_i = 1'b0;
    check("next_cycle_ready", bus.req_ready_o[0], 1);
    wait_acc(4'b0001, "acc_req0_reissue");
    step();
    send_rsp(0, 8'd70, 1'b0, 1'b1);
    step();

    // Reset with a request parked in the output stage discards everything.
    bus.sync_ready_i = 1'b0;
    set_req(2, 8'd80, 8'hA0);
    wait_acc(4'b0100, "acc_req2_reset");
    rst_n = 1'b0;
    #1;
    check("midrst_sync_valid", bus.sync_valid_o, 0);
    check("midrst_busy", bus.busy_o, 0);
    exp_up.delete();
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    bus.sync_ready_i = 1'b1;
    step();
    step();
    check("postrst_sync_valid", bus.sync_valid_o, 0);
    send_rsp(2, 8'd80, 1'b0, 1'b0);
    step();
    check("postrst_busy", bus.busy_o, 0);

`ifdef FSYNC_ARB_TIMEOUT_EN
    // Watchdog: no response, error pulse with stored level, late response dropped.
    set_req(0, 8'd90, 8'hB0);
    wait_acc(4'b0001, "acc_req0_tmo");
    exp_rsp.push_back('{src: 2'd0, lvl: 8'd90, err: 1'b1});
    for (int c = 0; c < 40 && exp_rsp.size() != 0; c++) step();
    check("tmo_pulse_seen", exp_rsp.size(), 0);
    set_req(0, 8'd91, 8'hB1);
    repeat (3) step();
    check("stale_blocks_req", bus.req_valid_i[0], 1);
    send_rsp(0, 8'd90, 1'b0, 1'b0);
    wait_acc(4'b0001, "acc_req0_after_stale");
    step();
    send_rsp(0, 8'd91, 1'b0, 1'b1);
    step();
`endif

    repeat (3) step();
    check("up_drain", exp_up.size(), 0);
    check("rsp_drain", exp_rsp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
